load_subword_reader: RTL and testbench
======================================

Name: load_subword_reader

Overview:
- Read-side counterpart of the data-memory sub-field write path. It services MIPS load requests (LB, LBU, LH, LHU, LW) against a word-organised synchronous data memory.
- Per request: issues one word read, selects the addressed byte or halfword lane, and sign- or zero-extends it.
- Returns the 32-bit result to the pipeline's MEM stage through a valid/ready handshake.
- Sits between the MEM-stage load control and the data-memory read port.

Parameters:
- ADDR_W, 10, byte-address width of req_addr. Word address is ADDR_W-2 bits.
- TAG_W, 5, width of the request tag (destination register number) echoed with the response.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  block can accept a request. High only in IDLE.
- req_addr  input  ADDR_W  byte address.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  input  1  1 zero-extends, 0 sign-extends. Ignored for word.
- req_tag  input  TAG_W  echoed on rsp_tag.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_W-2  word address = req_addr[ADDR_W-1:2].
- mem_gnt  input  1  memory accepted mem_req this cycle.
- mem_rvalid  input  1  mem_rdata valid this cycle.
- mem_rdata  input  32  read word.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  32  extended load result.
- rsp_err  output  1  misaligned or reserved-size request.
- rsp_tag  output  TAG_W  tag of the responding request.

Behaviour:
- Reset: async on rst_n low.
  - State goes to IDLE.
  - All registered outputs clear: rsp_valid=0, rsp_data=0, rsp_err=0, rsp_tag=0, mem_req=0, mem_addr=0.
  - Reset mid-transaction abandons the request. No response is produced, and a later mem_rvalid for it is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, size, unsigned and tag.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size=11: go to RESP with rsp_err=1, rsp_data=0, and no memory access.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1, mem_addr held stable.
  - On mem_gnt go to WAIT. Stay in REQ while mem_gnt=0.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, register the extracted result into rsp_data and go to RESP.
  - Data arriving in the same cycle as the grant is not legal. mem_rvalid is only sampled in WAIT.
- RESP:
  - rsp_valid=1. rsp_data, rsp_err and rsp_tag are held stable until rsp_ready=1.
  - On rsp_valid and rsp_ready, go to IDLE. There is no bypass to accept a new request in the same cycle.
- Latency: request accepted at edge 0, gnt sampled at edge 1, rvalid sampled at edge 2, rsp_valid high after edge 2. Minimum is 3 cycles request to response; each extra gnt/rvalid stall adds 1 cycle.
- Lane select (little-endian, default):
  - Byte lane k = addr[1:0] maps to bits [8k+7:8k].
  - Halfword at addr[1]=0 uses [15:0]; addr[1]=1 uses [31:16].
- Extension: bytes and halfwords are sign-extended from their MSB unless req_unsigned=1. Word loads pass through unchanged.
- Throughput: one outstanding request at a time.

Optional Feature:
- SUBWORD_BIG_ENDIAN_EN defined:
  - Byte lane k maps to bits [31-8k:24-8k].
  - Halfword at addr[1]=0 uses [31:16]; addr[1]=1 uses [15:0].
- Not defined: little-endian mapping as above.
- Word loads, alignment checks and timing are identical in both builds.

Test Plan:
- Setup: memory word 0x004 holds 0x80F17F02, mem_gnt and mem_rvalid ideal. LB addr 0x010 → rsp_data=0x00000002, rsp_valid high 3 cycles after acceptance, rsp_err=0.
- Same word: LB 0x013 → 0xFFFFFF80. LBU 0x013 → 0x00000080. LH 0x012 → 0xFFFF80F1. LHU 0x012 → 0x000080F1. LW 0x010 → 0x80F17F02.
- LH 0x011, tag 7 → no mem_req; rsp_err=1, rsp_data=0, rsp_tag=7 one cycle after acceptance. Size 11 gives the same result.
- Stalls: mem_gnt held low 2 cycles and mem_rvalid delayed 3 cycles → mem_addr stable throughout, response 5 cycles later than minimum. Then rsp_ready held low 4 cycles → rsp_data, rsp_tag and rsp_valid are stable, and req_ready=0 until the handshake completes.
- Reset: rst_n pulsed low while in WAIT → outputs go to 0 immediately. A subsequent mem_rvalid produces no rsp_valid, and req_ready=1 after release.
- With SUBWORD_BIG_ENDIAN_EN defined: LB 0x010 → 0xFFFFFF80. LHU 0x012 → 0x00007F02.

Source files
------------

// File: rtl/load_subword_reader.sv
// MIPS load reader: one word read per request, then byte/halfword lane select and extension.
// Define SUBWORD_BIG_ENDIAN_EN for big-endian lane mapping; little-endian otherwise.
module load_subword_reader #(
  parameter int ADDR_W = 10,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;

  logic              misaligned;
  logic [1:0]        byte_idx;
  logic              half_hi;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       result;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Big-endian simply mirrors the lane index; everything downstream is shared.
`ifdef SUBWORD_BIG_ENDIAN_EN
  assign byte_idx = ~lane_q;
  assign half_hi  = ~lane_q[1];
`else
  assign byte_idx = lane_q;
  assign half_hi  = lane_q[1];
`endif

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (byte_idx)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = half_hi ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   result = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
      2'b01:   result = {{16{~unsigned_q & half_sel[15]}}, half_sel};
      default: result = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    tag_d      = tag_q;
    data_d     = data_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lane_d     = req_addr[1:0];
          size_d     = req_size;
          unsigned_d = req_unsigned;
          tag_d      = req_tag;
          mem_addr_d = req_addr[ADDR_W-1:2];
          if (misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
            data_d  = 32'd0;
          end else begin
            state_d = REQ;
            err_d   = 1'b0;
          end
        end
      end
      REQ:  if (mem_gnt) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          data_d  = result;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_q     <= 2'd0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      tag_q      <= '0;
      data_q     <= 32'd0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign rsp_tag   = tag_q;

endmodule

// File: tb/tb_load_subword_reader.sv
// Directed bench for load_subword_reader; define SUBWORD_BIG_ENDIAN_EN to check the big-endian build.
module tb_load_subword_reader;
  localparam int ADDR_W = 10;
  localparam int TAG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [TAG_W-1:0]  req_tag;
  logic              mem_req;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [TAG_W-1:0]  rsp_tag;

  always #5 clk = ~clk;

  load_subword_reader #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_tag(req_tag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  logic [31:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]      obs_data;
  logic             obs_err;
  logic [TAG_W-1:0] obs_tag;
  int               obs_lat;
  bit               obs_timeout, obs_saw_req, obs_addr_ok, obs_hold_ok;
  bit               obs_ready_ok, obs_accept_ok, obs_done_ok;

  // Drives one load with optional grant/rvalid/response stalls; records what the DUT did.
  task automatic issue(input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                       input logic uns, input logic [TAG_W-1:0] tag,
                       input int gnt_stall, input int rv_stall, input int rsp_stall);
    int  gcnt;
    int  rcnt;
    bit  granted;
    gcnt = 0; rcnt = 0; granted = 1'b0;
    obs_saw_req = 1'b0; obs_addr_ok = 1'b1; obs_hold_ok = 1'b1; obs_ready_ok = 1'b1;
    @(negedge clk);
    obs_accept_ok = (req_ready === 1'b1);
    req_valid = 1'b1; req_addr = addr; req_size = size; req_unsigned = uns; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
    obs_lat = 0;
    while (rsp_valid !== 1'b1 && obs_lat < 40) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      if (req_ready !== 1'b0) obs_ready_ok = 1'b0;
      if (mem_req === 1'b1) begin
        obs_saw_req = 1'b1;
        if (mem_addr !== addr[ADDR_W-1:2]) obs_addr_ok = 1'b0;
        if (gcnt == gnt_stall) mem_gnt = 1'b1;
        else gcnt++;
      end else if (granted) begin
        if (mem_addr !== addr[ADDR_W-1:2]) obs_addr_ok = 1'b0;
        if (rcnt == rv_stall) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[addr[ADDR_W-1:2]];
        end else rcnt++;
      end
      @(negedge clk);
      if (mem_gnt) granted = 1'b1;
      obs_lat++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    obs_timeout = (rsp_valid !== 1'b1);
    obs_data = rsp_data; obs_err = rsp_err; obs_tag = rsp_tag;
    for (int i = 0; i < rsp_stall; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== obs_data || rsp_tag !== obs_tag || rsp_err !== obs_err)
        obs_hold_ok = 1'b0;
      if (req_ready !== 1'b0) obs_ready_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    obs_done_ok = (rsp_valid === 1'b0 && req_ready === 1'b1);
    $display("load addr=%h size=%0d uns=%0d tag=%0d -> data=%h err=%0d tag=%0d lat=%0d",
             addr, size, uns, tag, obs_data, obs_err, obs_tag, obs_lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_err, rsp_tag, mem_req, mem_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b data=%h err=%b tag=%h mem_req=%b mem_addr=%h, required all 0",
               rsp_valid, rsp_data, rsp_err, rsp_tag, mem_req, mem_addr);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lanes;
    logic [ADDR_W-1:0] a [10];
    logic [1:0]        s [10];
    logic              u [10];
    logic [31:0]       e [10];
    a[0] = 10'h010; s[0] = 2'b00; u[0] = 1'b0;
    a[1] = 10'h013; s[1] = 2'b00; u[1] = 1'b0;
    a[2] = 10'h013; s[2] = 2'b00; u[2] = 1'b1;
    a[3] = 10'h012; s[3] = 2'b01; u[3] = 1'b0;
    a[4] = 10'h012; s[4] = 2'b01; u[4] = 1'b1;
    a[5] = 10'h010; s[5] = 2'b10; u[5] = 1'b0;
    a[6] = 10'h011; s[6] = 2'b00; u[6] = 1'b0;
    a[7] = 10'h010; s[7] = 2'b01; u[7] = 1'b0;
    a[8] = 10'h012; s[8] = 2'b00; u[8] = 1'b0;
    a[9] = 10'h010; s[9] = 2'b10; u[9] = 1'b1;
`ifdef SUBWORD_BIG_ENDIAN_EN
    e[0] = 32'hFFFFFF80; e[1] = 32'h00000002; e[2] = 32'h00000002; e[3] = 32'h00007F02;
    e[4] = 32'h00007F02; e[5] = 32'h80F17F02; e[6] = 32'hFFFFFFF1; e[7] = 32'hFFFF80F1;
    e[8] = 32'h0000007F; e[9] = 32'h80F17F02;
`else
    e[0] = 32'h00000002; e[1] = 32'hFFFFFF80; e[2] = 32'h00000080; e[3] = 32'hFFFF80F1;
    e[4] = 32'h000080F1; e[5] = 32'h80F17F02; e[6] = 32'h0000007F; e[7] = 32'h00007F02;
    e[8] = 32'hFFFFFFF1; e[9] = 32'h80F17F02;
`endif
    for (int i = 0; i < 10; i++) begin
      issue(a[i], s[i], u[i], 5'(i + 1), 0, 0, 0);
      n_cmp++;
      if (obs_timeout || obs_data !== e[i]) begin
        n_bad++;
        $display("FAIL lane_data[%0d]: got %h (timeout=%0d) required %h", i, obs_data, obs_timeout, e[i]);
      end
      n_cmp++;
      if (obs_err !== 1'b0 || obs_tag !== 5'(i + 1)) begin
        n_bad++;
        $display("FAIL lane_err_tag[%0d]: err=%b tag=%0d required err=0 tag=%0d", i, obs_err, obs_tag, i + 1);
      end
      n_cmp++;
      if (obs_lat != 2 || !obs_saw_req || !obs_addr_ok || !obs_done_ok) begin
        n_bad++;
        $display("FAIL lane_timing[%0d]: lat=%0d saw_req=%0d addr_ok=%0d done_ok=%0d required 2/1/1/1",
                 i, obs_lat, obs_saw_req, obs_addr_ok, obs_done_ok);
      end
    end
  endtask

  task automatic test_misaligned;
    logic [ADDR_W-1:0] a [3];
    logic [1:0]        s [3];
    logic [TAG_W-1:0]  t [3];
    a[0] = 10'h011; s[0] = 2'b01; t[0] = 5'd7;
    a[1] = 10'h010; s[1] = 2'b11; t[1] = 5'd3;
    a[2] = 10'h012; s[2] = 2'b10; t[2] = 5'd12;
    for (int i = 0; i < 3; i++) begin
      issue(a[i], s[i], 1'b0, t[i], 0, 0, 0);
      n_cmp++;
      if (obs_err !== 1'b1 || obs_data !== 32'd0 || obs_tag !== t[i]) begin
        n_bad++;
        $display("FAIL misaligned[%0d]: err=%b data=%h tag=%0d required err=1 data=0 tag=%0d",
                 i, obs_err, obs_data, obs_tag, t[i]);
      end
      n_cmp++;
      if (obs_lat != 0 || obs_saw_req) begin
        n_bad++;
        $display("FAIL misaligned_timing[%0d]: lat=%0d saw_req=%0d required 0/0", i, obs_lat, obs_saw_req);
      end
    end
  endtask

  task automatic test_stalls;
    logic [31:0] e;
`ifdef SUBWORD_BIG_ENDIAN_EN
    e = 32'h00007F02;
`else
    e = 32'h000080F1;
`endif
    issue(10'h012, 2'b01, 1'b1, 5'd21, 2, 3, 4);
    n_cmp++;
    if (obs_timeout || obs_data !== e || obs_tag !== 5'd21 || obs_err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_data: data=%h tag=%0d err=%b required %h/21/0", obs_data, obs_tag, obs_err, e);
    end
    n_cmp++;
    if (obs_lat != 7) begin
      n_bad++;
      $display("FAIL stall_latency: lat=%0d required 7", obs_lat);
    end
    n_cmp++;
    if (!obs_addr_ok || !obs_hold_ok || !obs_ready_ok || !obs_done_ok) begin
      n_bad++;
      $display("FAIL stall_stability: addr_ok=%0d hold_ok=%0d ready_ok=%0d done_ok=%0d required all 1",
               obs_addr_ok, obs_hold_ok, obs_ready_ok, obs_done_ok);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e0, e1;
`ifdef SUBWORD_BIG_ENDIAN_EN
    e0 = 32'hFFFF8765; e1 = 32'h00000034;
`else
    e0 = 32'h00001234; e1 = 32'h00000087;
`endif
    issue(10'h016, 2'b01, 1'b0, 5'd30, 0, 0, 0);
    n_cmp++;
    if (obs_data !== e0 || obs_tag !== 5'd30) begin
      n_bad++;
      $display("FAIL b2b_first: data=%h tag=%0d required %h/30", obs_data, obs_tag, e0);
    end
    issue(10'h015, 2'b00, 1'b1, 5'd31, 0, 1, 1);
    n_cmp++;
    if (!obs_accept_ok || obs_data !== e1 || obs_tag !== 5'd31 || obs_lat != 3) begin
      n_bad++;
      $display("FAIL b2b_second: accept=%0d data=%h tag=%0d lat=%0d required 1/%h/31/3",
               obs_accept_ok, obs_data, obs_tag, obs_lat, e1);
    end
  endtask

  task automatic test_reset_midflight;
    bit stray;
    stray = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 10'h010; req_size = 2'b10; req_unsigned = 1'b0; req_tag = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_addr !== 8'h04 || rsp_tag !== 5'd9 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midflight_wait: mem_req=%b mem_addr=%h tag=%0d ready=%b required 0/04/9/0",
               mem_req, mem_addr, rsp_tag, req_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_err, rsp_tag, mem_req, mem_addr} !== '0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midflight_reset: valid=%b data=%h err=%b tag=%h mem_req=%b mem_addr=%h ready=%b required 0s and ready 1",
               rsp_valid, rsp_data, rsp_err, rsp_tag, mem_req, mem_addr, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h80F17F02;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'd0) stray = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (stray) begin
      n_bad++;
      $display("FAIL midflight_stray_rvalid: valid=%b ready=%b data=%h required 0/1/0", rsp_valid, req_ready, rsp_data);
    end
    $display("reset during WAIT handled, stray rvalid ignored=%0d", !stray);
  endtask

  initial begin
    mem[4] = 32'h80F17F02;
    mem[5] = 32'h12348765;
    req_valid = 1'b0; req_addr = '0; req_size = 2'b00; req_unsigned = 1'b0; req_tag = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; rsp_ready = 1'b0;
    test_reset();
    test_lanes();
    test_misaligned();
    test_stalls();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
